// File: rtl/camera_burst_pkg.sv
// Shared types and helpers for the camera line-FIFO burst scheduler.
package camera_burst_pkg;

    localparam int STATE_W    = 3;
    localparam int MAX_RD_LAT = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        REQ       = 3'd2,
        BURST     = 3'd3,
        DRAIN     = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/camera_rd_lat_pipe.sv
// Valid shift register matching the FIFO rd_en-to-rd_data latency.
module camera_rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/camera_fifo_burst_ctrl.sv
// Read-side scheduler: turns FIFO water level into fixed-length DDR write bursts per frame.
// Handshake: wr_req/wr_addr/wr_len hold until a one-cycle wr_grant; beats follow with no backpressure.
module camera_fifo_burst_ctrl
    import camera_burst_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEVEL_W   = 11,
    parameter int ADDR_W    = 28,
    parameter int BURST_LEN = 64,
    parameter int BLEN_W    = 8,
    parameter int FRAME_W   = 22,
    parameter int RD_LAT    = 1,
    parameter int ADDR_INC  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [FRAME_W-1:0] cfg_frame_words,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_rd_empty,
    input  logic [LEVEL_W-1:0] fifo_rd_level,
    output logic               wr_req,
    input  logic               wr_grant,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [BLEN_W-1:0]  wr_len,
    output logic [DATA_W-1:0]  wr_data,
    output logic               wr_data_valid,
    input  logic               wr_done,
    output logic               frame_done,
    output logic               busy,
    output logic               err_overrun,
    output logic               err_underflow,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int DRAIN_W = $clog2(MAX_RD_LAT + 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   pend_base;
    logic [FRAME_W-1:0]  words_left;
    logic [FRAME_W-1:0]  pend_words;
    logic [FRAME_W-1:0]  words_next;
    logic                pend_restart;
    logic                done_seen;
    logic [BLEN_W-1:0]   beat_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [31:0]         blen;
    logic                restart_now;

    assign blen        = min_len(32'(BURST_LEN), 32'(words_left));
    assign words_next  = words_left - FRAME_W'(wr_len);
    // A zero-length restart carries nothing to reload, so it only flags the overrun.
    assign restart_now = frame_start && (state != IDLE) && (cfg_frame_words != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            pend_base     <= '0;
            words_left    <= '0;
            pend_words    <= '0;
            pend_restart  <= 1'b0;
            done_seen     <= 1'b0;
            beat_cnt      <= '0;
            drain_cnt     <= '0;
            fifo_rd_en    <= 1'b0;
            wr_req        <= 1'b0;
            wr_addr       <= '0;
            wr_len        <= '0;
            frame_done    <= 1'b0;
            err_overrun   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fifo_rd_en && fifo_rd_empty) err_underflow <= 1'b1;
            if (wr_done && (state == BURST || state == DRAIN)) done_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_start && cfg_frame_words != '0) begin
                        addr_q     <= cfg_base_addr;
                        words_left <= cfg_frame_words;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    if (pend_restart) begin
                        addr_q       <= pend_base;
                        words_left   <= pend_words;
                        pend_restart <= 1'b0;
                    end else if (words_left == '0) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (32'(fifo_rd_level) >= blen) begin
                        wr_addr <= addr_q;
                        wr_len  <= BLEN_W'(blen);
                        wr_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (wr_grant) begin
                        wr_req     <= 1'b0;
                        fifo_rd_en <= 1'b1;
                        beat_cnt   <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == wr_len - 1'b1) begin
                        fifo_rd_en <= 1'b0;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(RD_LAT - 1)) state <= WAIT_DONE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (wr_done || done_seen) begin
                        done_seen  <= 1'b0;
                        addr_q     <= addr_q + ADDR_W'(32'(wr_len) * 32'(ADDR_INC));
                        words_left <= words_next;
                        // Last burst finishes the frame here unless a restart has aborted it.
                        if (words_next == '0 && !pend_restart && !restart_now) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (frame_start && state != IDLE) err_overrun <= 1'b1;
            if (restart_now) begin
                pend_restart <= 1'b1;
                pend_base    <= cfg_base_addr;
                pend_words   <= cfg_frame_words;
            end
        end
    end

    camera_rd_lat_pipe #(
        .DEPTH(RD_LAT)
    ) u_rd_lat_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (fifo_rd_en),
        .dout (wr_data_valid)
    );

    assign wr_data   = fifo_rd_data;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
